// File: rtl/axis_downsizer_if.sv
// AXI-Stream beat bundle shared by the wide input and narrow output sides of the downsizer.
// The master drives data/valid/last and the slave answers with ready.
interface axis_downsizer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] TDATA;
    logic             TVALID;
    logic             TLAST;
    logic             TREADY;

    modport master (output TDATA, output TVALID, output TLAST, input TREADY);
    modport slave  (input TDATA, input TVALID, input TLAST, output TREADY);
endinterface

// File: rtl/axis_downsizer.sv
// AXI-Stream width down-converter: captures one wide beat and replays SLICES narrow fields,
// least-significant first, with registered TX outputs and full ready/valid backpressure.
module axis_downsizer #(
    parameter int DIN_WIDTH  = 256,
    parameter int DOUT_WIDTH = 32,
    parameter int LOW_BIT    = 0,
    parameter int SLICES     = 8
) (
    input  logic                clk,
    input  logic                reset,
    axis_downsizer_if.slave     axis_rx_i,
    axis_downsizer_if.master    axis_tx_o
);
    localparam int HOLD_W = SLICES * DOUT_WIDTH;
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t               state_q;
    logic [HOLD_W-1:0]    hold_q;
    logic                 last_q;
    logic [IDX_W-1:0]     idx_q;
    logic [DOUT_WIDTH-1:0] data_q;
    logic                 tlast_q;

    logic                 onLastSlice;
    logic                 rxReady;
    logic                 rxFire;
    logic                 txFire;
    logic [IDX_W-1:0]     nextIdx;

    // A new beat is taken either when idle or exactly as the final slice leaves,
    // which keeps TX valid continuous across back-to-back input beats.
    assign onLastSlice = (idx_q == LAST_IDX);
    assign rxReady     = !reset && ((state_q == IDLE) || (axis_tx_o.TREADY && onLastSlice));
    assign rxFire      = axis_rx_i.TVALID && rxReady;
    assign txFire      = (state_q == BUSY) && axis_tx_o.TREADY;
    assign nextIdx     = idx_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            tlast_q <= 1'b0;
        end else if (rxFire) begin
            state_q <= BUSY;
            hold_q  <= axis_rx_i.TDATA[LOW_BIT +: HOLD_W];
            last_q  <= axis_rx_i.TLAST;
            idx_q   <= '0;
            data_q  <= axis_rx_i.TDATA[LOW_BIT +: DOUT_WIDTH];
            tlast_q <= axis_rx_i.TLAST && (SLICES == 1);
        end else if (txFire) begin
            if (!onLastSlice) begin
                idx_q   <= nextIdx;
                data_q  <= hold_q[int'(nextIdx) * DOUT_WIDTH +: DOUT_WIDTH];
                tlast_q <= last_q && (nextIdx == LAST_IDX);
            end else begin
                state_q <= IDLE;
                idx_q   <= '0;
            end
        end
    end

    assign axis_rx_i.TREADY = rxReady;
    assign axis_tx_o.TDATA  = data_q;
    assign axis_tx_o.TVALID = (state_q == BUSY);
    assign axis_tx_o.TLAST  = tlast_q;
endmodule

// File: tb/tb_axis_downsizer.sv
// Scoreboard bench for axis_downsizer: default 256->8x32 instance plus an offset 64->3x16 instance.
// Stimulus pushes expected slices into queues; negedge monitors pop and compare on each TX transfer.
module tb_axis_downsizer;
    logic clk;
    logic reset;

    axis_downsizer_if #(.WIDTH(256)) rxIf ();
    axis_downsizer_if #(.WIDTH(32))  txIf ();
    axis_downsizer_if #(.WIDTH(64))  rxOfsIf ();
    axis_downsizer_if #(.WIDTH(16))  txOfsIf ();

    axis_downsizer dut (
        .clk       (clk),
        .reset     (reset),
        .axis_rx_i (rxIf),
        .axis_tx_o (txIf)
    );

    axis_downsizer #(
        .DIN_WIDTH  (64),
        .DOUT_WIDTH (16),
        .LOW_BIT    (16),
        .SLICES     (3)
    ) dutOfs (
        .clk       (clk),
        .reset     (reset),
        .axis_rx_i (rxOfsIf),
        .axis_tx_o (txOfsIf)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          pos;
    } exp_t;

    exp_t scoreQ[$];
    exp_t ofsQ[$];
    int   checks = 0;
    int   fails  = 0;
    int   txCount = 0;
    logic prevStall = 1'b0;
    logic [31:0] prevData;
    logic prevLast;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic flagFail(input string name);
        checks++;
        fails++;
        $display("[TB] FAIL %s: condition not met at %0t", name, $time);
    endtask

    // Waits for a handshake on the default instance and records its eight expected slices.
    task automatic applyStimulus(input logic [255:0] data, input logic last);
        bit accepted = 0;
        rxIf.TDATA  = data;
        rxIf.TLAST  = last;
        rxIf.TVALID = 1'b1;
        for (int c = 0; c < 100 && !accepted; c++) begin
            @(negedge clk);
            if (rxIf.TREADY) accepted = 1;
        end
        if (!accepted) flagFail("rxHandshakeTimeout");
        else begin
            for (int k = 0; k < 8; k++) begin
                exp_t e;
                e.data = data[k*32 +: 32];
                e.last = last && (k == 7);
                e.pos  = k;
                scoreQ.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        rxIf.TVALID = 1'b0;
    endtask

    task automatic applyStimulusOfs(input logic [63:0] data, input logic last,
                                    input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2);
        bit accepted = 0;
        exp_t e;
        rxOfsIf.TDATA  = data;
        rxOfsIf.TLAST  = last;
        rxOfsIf.TVALID = 1'b1;
        for (int c = 0; c < 100 && !accepted; c++) begin
            @(negedge clk);
            if (rxOfsIf.TREADY) accepted = 1;
        end
        if (!accepted) flagFail("rxOfsHandshakeTimeout");
        else begin
            e.last = 1'b0; e.pos = 0; e.data = {16'h0, s0}; ofsQ.push_back(e);
            e.pos = 1; e.data = {16'h0, s1}; ofsQ.push_back(e);
            e.last = last; e.pos = 2; e.data = {16'h0, s2}; ofsQ.push_back(e);
        end
        @(posedge clk);
        #1;
        rxOfsIf.TVALID = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        bit done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (scoreQ.size() == 0 && ofsQ.size() == 0 && !txIf.TVALID && !txOfsIf.TVALID) done = 1;
        end
        if (!done) flagFail(name);
    endtask

    // Default-instance monitor: checks data/last per transfer, stall stability and RX ready timing.
    always @(negedge clk) begin
        if (!reset && txIf.TVALID) begin
            if (prevStall) begin
                checkOutput("stallData", txIf.TDATA, prevData);
                checkOutput("stallLast", txIf.TLAST, prevLast);
            end
            if (scoreQ.size() == 0) begin
                flagFail("unexpectedTxValid");
            end else begin
                checkOutput("rxReady", rxIf.TREADY, txIf.TREADY && (scoreQ[0].pos == 7));
                if (txIf.TREADY) begin
                    exp_t e;
                    e = scoreQ.pop_front();
                    checkOutput("txData", txIf.TDATA, e.data);
                    checkOutput("txLast", txIf.TLAST, e.last);
                    txCount++;
                end
            end
            prevStall = !txIf.TREADY;
            prevData  = txIf.TDATA;
            prevLast  = txIf.TLAST;
        end else begin
            prevStall = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!reset && txOfsIf.TVALID && txOfsIf.TREADY) begin
            if (ofsQ.size() == 0) flagFail("unexpectedOfsTxValid");
            else begin
                exp_t e;
                e = ofsQ.pop_front();
                checkOutput("ofsData", txOfsIf.TDATA, e.data);
                checkOutput("ofsLast", txOfsIf.TLAST, e.last);
            end
        end
    end

    initial begin
        logic [255:0] beatA;
        logic [255:0] beatB [3];
        logic [3:0]   readyPattern;
        int           gaps;
        bit           seen;

        reset = 1'b1;
        rxIf.TVALID = 1'b0; rxIf.TLAST = 1'b0; rxIf.TDATA = '0;
        txIf.TREADY = 1'b1;
        rxOfsIf.TVALID = 1'b0; rxOfsIf.TLAST = 1'b0; rxOfsIf.TDATA = '0;
        txOfsIf.TREADY = 1'b1;

        for (int k = 0; k < 8; k++) beatA[k*32 +: 32] = 32'h11111111 * k;
        beatB[0] = 256'hA7A6A5A4_A3A2A1A0_9F9E9D9C_9B9A9998_17161514_13121110_0F0E0D0C_0B0A0908;
        beatB[1] = 256'hDEADBEEF_CAFEBABE_01234567_89ABCDEF_FEDCBA98_76543210_0BADF00D_FACEB00C;
        beatB[2] = 256'h80000001_40000002_20000004_10000008_08000010_04000020_02000040_01000080;

        // Reset held for three cycles: outputs cleared and RX ready low throughout.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("resetTvalid", txIf.TVALID, 1'b0);
            checkOutput("resetTdata", txIf.TDATA, 32'h0);
            checkOutput("resetTlast", txIf.TLAST, 1'b0);
            checkOutput("resetRxReady", rxIf.TREADY, 1'b0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idleRxReady", rxIf.TREADY, 1'b1);
        checkOutput("idleOfsRxReady", rxOfsIf.TREADY, 1'b1);
        checkOutput("idleTvalid", txIf.TVALID, 1'b0);

        $display("[TB] single beat, default config");
        @(posedge clk); #1;
        applyStimulus(beatA, 1'b1);
        waitDrain("drainSingle");

        $display("[TB] back-to-back beats");
        gaps = 0;
        seen = 0;
        @(posedge clk); #1;
        fork
            begin
                applyStimulus(beatB[0], 1'b0);
                applyStimulus(beatB[1], 1'b0);
                applyStimulus(beatB[2], 1'b1);
            end
            begin
                for (int c = 0; c < 50 && !seen; c++) begin
                    @(negedge clk);
                    if (txIf.TVALID) seen = 1;
                end
                for (int c = 1; c < 24; c++) begin
                    @(negedge clk);
                    if (!txIf.TVALID) gaps++;
                end
            end
        join
        checkOutput("b2bStarted", seen, 1'b1);
        checkOutput("b2bGaps", gaps, 0);
        waitDrain("drainB2B");

        $display("[TB] backpressure");
        readyPattern = 4'b1001;
        @(posedge clk); #1;
        fork
            applyStimulus(beatA ^ beatB[1], 1'b1);
            begin
                for (int c = 0; c < 24; c++) begin
                    txIf.TREADY = readyPattern[3 - (c % 4)];
                    @(posedge clk); #1;
                end
                txIf.TREADY = 1'b1;
            end
        join
        waitDrain("drainBackpressure");

        $display("[TB] offset configuration");
        @(posedge clk); #1;
        applyStimulusOfs(64'hDDDD_CCCC_BBBB_AAAA, 1'b1, 16'hBBBB, 16'hCCCC, 16'hDDDD);
        waitDrain("drainOffset");

        $display("[TB] reset mid-beat");
        @(posedge clk); #1;
        txCount = 0;
        applyStimulus(beatB[2], 1'b1);
        for (int c = 0; c < 20 && txCount < 3; c++) @(posedge clk);
        #1;
        checkOutput("midBeatCount", txCount, 3);
        txIf.TREADY = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midResetRxReady", rxIf.TREADY, 1'b0);
        @(posedge clk); #1;
        scoreQ.delete();
        @(negedge clk);
        checkOutput("postResetTvalid", txIf.TVALID, 1'b0);
        checkOutput("postResetTdata", txIf.TDATA, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        txIf.TREADY = 1'b1;
        applyStimulus(beatB[0], 1'b1);
        waitDrain("drainAfterReset");

        checkOutput("scoreboardEmpty", scoreQ.size(), 0);
        checkOutput("ofsScoreboardEmpty", ofsQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
